// File: rtl/mask_pkg.sv
// Shared definitions for the mask stream reader.
// Provides the default packet and beat widths, the controller state type and a
// helper that derives how many output beats one regfile packet holds.
package mask_pkg;

    localparam int unsigned MASK_LANES      = 8;
    localparam int unsigned MASK_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mask_state_e;

    // Beats carried by one packet; DATA_WIDTH is required to be a multiple of LANES.
    function automatic int unsigned beats_per_pkt(input int unsigned data_width,
                                                  input int unsigned lanes);
        return data_width / lanes;
    endfunction

endpackage

// File: rtl/mask_stream_reader_if.sv
// Bus bundle for the mask stream reader.
// Carries the mask regfile read port (rd_en, rd_addr, rd_off, rd_data) and the
// outgoing beat stream (m_valid, m_ready, m_bits, m_last).
//   master : the reader (drives reads and beats, receives rd_data and m_ready)
//   slave  : the environment (regfile + masked-execution control)
interface mask_stream_reader_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned OFF_BITS   = 8,
    parameter int unsigned LANES      = 8
);

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [OFF_BITS-1:0]   rd_off;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [LANES-1:0]      m_bits;
    logic                  m_last;

    modport master (
        output rd_en, rd_addr, rd_off, m_valid, m_bits, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, rd_off, m_valid, m_bits, m_last,
        output rd_data, m_ready
    );

endinterface

// File: rtl/mask_pkt_fifo.sv
// Two-entry packet buffer between the regfile read port and the beat unpacker.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/wdata_i  write one packet (ignored when full)
//   pop_i           drop the head packet (ignored when empty)
//   rdata_o         head packet
//   count_o         occupancy 0..2
//   full_o/empty_o  occupancy flags
module mask_pkt_fifo
    import mask_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MASK_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mask_stream_reader.sv
// Streams the mask bits of one vector register as LANES-bit beats.
// A start command latches (vs_addr, vl) and the reader fetches packets 0,1,2,...
// of that register, buffers at most two (held or in flight), and unpacks each
// packet LSB-first onto a valid/ready stream. Bits past vl are forced to 0.
// Optional build macro MASK_READER_INVERT_EN adds an invert input that
// complements in-range bits of the command.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, vs_addr, vl command (sampled only while busy=0)
//   invert            complement mask bits (MASK_READER_INVERT_EN only)
//   busy, done        command in progress, one-cycle completion pulse
//   bus               regfile read port and beat stream (master side)
module mask_stream_reader
    import mask_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = MASK_DATA_WIDTH,
    parameter int unsigned OFF_BITS   = 8,
    parameter int unsigned LANES      = MASK_LANES,
    parameter int unsigned VL_WIDTH   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vs_addr,
    input  logic [VL_WIDTH-1:0]   vl,
`ifdef MASK_READER_INVERT_EN
    input  logic                  invert,
`endif
    output logic                  busy,
    output logic                  done,
    mask_stream_reader_if.master  bus
);

    localparam int unsigned Bpp      = beats_per_pkt(DATA_WIDTH, LANES);
    localparam int unsigned BeatIdxW = (Bpp > 1) ? $clog2(Bpp) : 1;
    localparam int unsigned ElemW    = VL_WIDTH + 1;
    localparam logic [BeatIdxW-1:0] LastBeatIdx = BeatIdxW'(Bpp - 1);

    mask_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [VL_WIDTH-1:0]   vl_q, vl_d;
    logic [ElemW-1:0]      pkts_left_q, pkts_left_d;
    logic [OFF_BITS-1:0]   req_off_q, req_off_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [OFF_BITS-1:0]   rd_off_q, rd_off_d;
    logic                  inflight_q;
    logic [BeatIdxW-1:0]   beat_idx_q, beat_idx_d;
    logic [ElemW-1:0]      elem_base_q, elem_base_d;
    logic                  invert_q, invert_d;
    logic                  invert_in;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [1:0]            fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_pop;

    logic                  rd_en_int;
    logic                  m_valid_int, m_last_int, hs;
    logic [31:0]           shamt;
    logic [DATA_WIDTH-1:0] pkt_shifted;
    logic [LANES-1:0]      beat_bits;

`ifdef MASK_READER_INVERT_EN
    assign invert_in = invert;
`else
    assign invert_in = 1'b0;
`endif

    mask_pkt_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pkt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .wdata_i (bus.rd_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Datapath: beat extraction, tail zeroing, read issue and handshake decode.
    always_comb begin
        m_valid_int = (state_q == StRun) && !fifo_empty;
        shamt       = LANES * 32'(beat_idx_q);
        pkt_shifted = fifo_rdata >> shamt;
        beat_bits   = pkt_shifted[LANES-1:0] ^ {LANES{invert_q}};
        for (int unsigned j = 0; j < LANES; j++) begin
            if ((elem_base_q + ElemW'(j)) >= {1'b0, vl_q}) begin
                beat_bits[j] = 1'b0;
            end
        end
        if (!m_valid_int) begin
            beat_bits = '0;
        end
        m_last_int = m_valid_int && ((elem_base_q + ElemW'(LANES)) >= {1'b0, vl_q});
        hs         = m_valid_int && bus.m_ready;
        // The final packet may be partial, so m_last also retires the head.
        fifo_pop   = hs && ((beat_idx_q == LastBeatIdx) || m_last_int);
        // Held packets plus the one in flight never exceed the buffer depth.
        rd_en_int  = (state_q == StRun) && (pkts_left_q != '0) && !fifo_full &&
                     (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
    end

    // Controller next state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        vl_d        = vl_q;
        pkts_left_d = pkts_left_q;
        req_off_d   = req_off_q;
        rd_addr_d   = rd_addr_q;
        rd_off_d    = rd_off_q;
        beat_idx_d  = beat_idx_q;
        elem_base_d = elem_base_q;
        invert_d    = invert_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    addr_d      = vs_addr;
                    vl_d        = vl;
                    invert_d    = invert_in;
                    pkts_left_d = ({1'b0, vl} + ElemW'(DATA_WIDTH - 1)) / ElemW'(DATA_WIDTH);
                    req_off_d   = '0;
                    beat_idx_d  = '0;
                    elem_base_d = '0;
                    state_d     = (vl == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en_int) begin
                    pkts_left_d = pkts_left_q - 1'b1;
                    req_off_d   = req_off_q + 1'b1;
                    rd_addr_d   = addr_q;
                    rd_off_d    = req_off_q;
                end
                if (hs) begin
                    elem_base_d = elem_base_q + ElemW'(LANES);
                    beat_idx_d  = fifo_pop ? '0 : beat_idx_q + 1'b1;
                    if (m_last_int) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            vl_q        <= '0;
            pkts_left_q <= '0;
            req_off_q   <= '0;
            rd_addr_q   <= '0;
            rd_off_q    <= '0;
            inflight_q  <= 1'b0;
            beat_idx_q  <= '0;
            elem_base_q <= '0;
            invert_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            vl_q        <= vl_d;
            pkts_left_q <= pkts_left_d;
            req_off_q   <= req_off_d;
            rd_addr_q   <= rd_addr_d;
            rd_off_q    <= rd_off_d;
            inflight_q  <= rd_en_int;
            beat_idx_q  <= beat_idx_d;
            elem_base_q <= elem_base_d;
            invert_q    <= invert_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign bus.rd_en   = rd_en_int;
    // Address/offset show the current request, otherwise the last one issued.
    assign bus.rd_addr = rd_en_int ? addr_q : rd_addr_q;
    assign bus.rd_off  = rd_en_int ? req_off_q : rd_off_q;
    assign bus.m_valid = m_valid_int;
    assign bus.m_bits  = beat_bits;
    assign bus.m_last  = m_last_int;

endmodule

// File: tb/tb_mask_stream_reader.sv
// Self-checking bench for mask_stream_reader: random regfile contents and
// commands, compared beat by beat against an element-level reference model.
module tb_mask_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  vs_addr;
    logic [14:0] vl;
    logic        busy, done;
`ifdef MASK_READER_INVERT_EN
    logic        invert;
`endif

    always #5 clk = ~clk;

    mask_stream_reader_if bus_if ();

    mask_stream_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .vs_addr (vs_addr),
        .vl      (vl),
`ifdef MASK_READER_INVERT_EN
        .invert  (invert),
`endif
        .busy    (busy),
        .done    (done),
        .bus     (bus_if)
    );

    logic [63:0] mem [32][16];
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: element e lives in packet e/64, bit e%64; out-of-range bits are 0.
    function automatic logic [7:0] exp_beat(input logic [4:0] a, input int b, input int n,
                                            input logic inv);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            int e;
            logic [63:0] p;
            e = b * 8 + j;
            if (e < n) begin
                p = mem[a][e / 64];
                r[j] = p[e % 64] ^ inv;
            end
        end
        return r;
    endfunction

    // Regfile model: data appears the cycle after the request, garbage otherwise.
    logic       pend_v;
    logic [4:0] pend_a;
    logic [7:0] pend_o;
    always @(negedge clk) begin
        if (pend_v === 1'b1 && pend_o < 8'd16) bus_if.rd_data = mem[pend_a][pend_o[3:0]];
        else bus_if.rd_data = {$urandom, $urandom};
        pend_v = bus_if.rd_en;
        pend_a = bus_if.rd_addr;
        pend_o = bus_if.rd_off;
    end

    // Issue one command at a negedge with busy=0 and consume its stream.
    // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1.
    // abort_at >= 0 pulls reset while that beat index is offered.
    task automatic run_cmd(input logic [4:0] a, input int n, input logic inv, input int rmode,
                           input int abort_at);
        int nb, np, cyc, acc, reads, k, limit;
        bit last_seen, finished, prev_stall;
        logic [7:0] prev_bits;
        logic prev_last, first_valid_seen;
        logic [3:0] pat;
        pat = 4'b1001;
        nb = (n + 7) / 8;
        np = (n + 63) / 64;
        start   = 1'b1;
        vs_addr = a;
        vl      = 15'(n);
`ifdef MASK_READER_INVERT_EN
        invert  = inv;
`endif
        @(negedge clk);
        start   = 1'b0;
        vs_addr = 5'($urandom);
        vl      = 15'($urandom);
`ifdef MASK_READER_INVERT_EN
        invert  = ~inv;
`endif
        if (n == 0) begin
            check_eq("z_done", done, 1);
            check_eq("z_busy", busy, 0);
            check_eq("z_rd_en", bus_if.rd_en, 0);
            check_eq("z_valid", bus_if.m_valid, 0);
            @(negedge clk);
            check_eq("z_done_once", done, 0);
            check_eq("z_rd_en2", bus_if.rd_en, 0);
            check_eq("z_valid2", bus_if.m_valid, 0);
            return;
        end
        check_eq("busy_t1", busy, 1);
        check_eq("first_rd", {bus_if.rd_en, bus_if.rd_off}, {1'b1, 8'h00});
        cyc = 1; acc = 0; reads = 0; k = 0;
        limit = 20 * nb + 40;
        last_seen = 0; finished = 0; prev_stall = 0; first_valid_seen = 0;
        prev_bits = '0; prev_last = 1'b0;
        while (!finished) begin
            if (cyc > limit) begin
                check_eq("timeout", cyc, limit);
                break;
            end
            if (last_seen) begin
                check_eq("done", done, 1);
                check_eq("done_busy", busy, 0);
                if (rmode == 0) check_eq("done_cyc", cyc, nb + 3);
                finished = 1;
                break;
            end
            check_eq("no_done", done, 0);
            if (bus_if.rd_en) begin
                check_eq("rd_addr", bus_if.rd_addr, a);
                check_eq("rd_off", bus_if.rd_off, reads);
                reads++;
                check_eq("outstanding", reads <= acc / 8 + 2, 1);
            end
            if (abort_at >= 0 && acc == abort_at && bus_if.m_valid) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_rd_en", bus_if.rd_en, 0);
                check_eq("rst_valid", bus_if.m_valid, 0);
                check_eq("rst_last", bus_if.m_last, 0);
                check_eq("rst_rd_addr", bus_if.rd_addr, 0);
                check_eq("rst_rd_off", bus_if.rd_off, 0);
                check_eq("rst_bits", bus_if.m_bits, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (prev_stall) begin
                check_eq("hold_valid", bus_if.m_valid, 1);
                check_eq("hold_bits", bus_if.m_bits, prev_bits);
                check_eq("hold_last", bus_if.m_last, prev_last);
            end
            if (bus_if.m_valid && !first_valid_seen) begin
                first_valid_seen = 1'b1;
                check_eq("first_valid_cyc", cyc, 3);
            end
            case (rmode)
                0:       bus_if.m_ready = 1'b1;
                1:       bus_if.m_ready = 1'($urandom_range(0, 1));
                default: begin
                    bus_if.m_ready = pat[k % 4];
                    if (bus_if.m_valid) k++;
                end
            endcase
            if (bus_if.m_valid && bus_if.m_ready) begin
                check_eq("bits", bus_if.m_bits, exp_beat(a, acc, n, inv));
                check_eq("last", bus_if.m_last, acc == nb - 1);
                if (bus_if.m_last) last_seen = 1;
                acc++;
            end
            prev_stall = bus_if.m_valid && !bus_if.m_ready;
            prev_bits  = bus_if.m_bits;
            prev_last  = bus_if.m_last;
            @(negedge clk);
            cyc++;
        end
        check_eq("beats", acc, nb);
        check_eq("reads", reads, np);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic inv;
        rst_n = 1'b0;
        start = 1'b0;
        vs_addr = '0;
        vl = '0;
        bus_if.m_ready = 1'b0;
`ifdef MASK_READER_INVERT_EN
        invert = 1'b0;
`endif
        for (int a = 0; a < 32; a++)
            for (int p = 0; p < 16; p++) mem[a][p] = {$urandom, $urandom};

        repeat (2) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_rd_en", bus_if.rd_en, 0);
        check_eq("reset_valid", bus_if.m_valid, 0);
        check_eq("reset_last", bus_if.m_last, 0);
        check_eq("reset_rd_addr", bus_if.rd_addr, 0);
        check_eq("reset_rd_off", bus_if.rd_off, 0);
        check_eq("reset_bits", bus_if.m_bits, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[3][0] = 64'h8000_0000_0000_0001;
        run_cmd(5'd3, 64, 1'b0, 0, -1);
        run_cmd(5'd7, 130, 1'b0, 0, -1);
        run_cmd(5'd1, 0, 1'b0, 0, -1);
        run_cmd(5'd9, 200, 1'b0, 2, -1);
        run_cmd(5'd12, 256, 1'b0, 0, 4);
        run_cmd(5'd12, 256, 1'b0, 0, -1);
`ifdef MASK_READER_INVERT_EN
        mem[5][0] = 64'h0;
        run_cmd(5'd5, 12, 1'b1, 0, -1);
`endif
        for (int i = 0; i < 20; i++) begin
            inv = 1'b0;
`ifdef MASK_READER_INVERT_EN
            inv = 1'($urandom_range(0, 1));
`endif
            run_cmd(5'($urandom), (i % 4 == 0) ? int'($urandom_range(1, 20)) :
                    int'($urandom_range(0, 1023)), inv, int'($urandom_range(0, 2)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
